// File: rtl/burst_read_engine.sv
// burst_read_engine: requests a bus burst and packs returned beats
// into a word-indexed data register, with length checks and error flag.
// Ports: clk_i/reset_i; start_i, addr_i, len_words_i start a burst;
// busy_o, done_o, error_o, words_o, data_reg_o report progress/result;
// req_o, addr_o, len_o, grant_i, read_valid_i, read_data_i, bus_error_i
// form the bus handshake.
// Optional watchdog: define BURST_RD_TIMEOUT_EN.
module burst_read_engine #(
  parameter  int BUS_W          = 64,
  parameter  int MAX_WORDS      = 8,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int LW             = $clog2(MAX_WORDS) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [31:0]            addr_i,
  input  logic [LW-1:0]          len_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [LW-1:0]          words_o,
  output logic [MAX_WORDS*32-1:0] data_reg_o,
  output logic                   req_o,
  output logic [31:0]            addr_o,
  output logic [LW-1:0]          len_o,
  input  logic                   grant_i,
  input  logic                   read_valid_i,
  input  logic [BUS_W-1:0]       read_data_i,
  input  logic                   bus_error_i
);

  localparam int BEAT = BUS_W / 32;

  if (BUS_W != 32 && BUS_W != 64 && BUS_W != 128) begin : g_bad_bus
    $error("burst_read_engine: BUS_W must be 32, 64 or 128");
  end
  if (MAX_WORDS < 2 || MAX_WORDS > 64 ||
      (MAX_WORDS & (MAX_WORDS - 1)) != 0) begin : g_bad_words
    $error("burst_read_engine: MAX_WORDS must be a power of two, 2..64");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("burst_read_engine: TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ASK,
    RD_GRANTED,
    RD_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          words_q, words_d;
  logic [MAX_WORDS*32-1:0] data_q, data_d;
  logic                   err_q, err_d;
  logic                   pulse_q, pulse_d;
  logic                   beat;
  logic                   timeout;
  int                     sum_w;

  assign beat = (state_q == RD_GRANTED) && read_valid_i;

`ifdef BURST_RD_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;

  // A beat in the same cycle restarts the count instead of timing out.
  assign timeout = (wd_q == WDW'(TIMEOUT_CYCLES - 1)) && !beat;

  // Entry from idle and every beat restart the count.
  always_comb begin
    wd_d = '0;
    if ((state_d == RD_ASK || state_d == RD_GRANTED) &&
        state_q != RD_IDLE && !beat)
      wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    words_d = words_q;
    data_d  = data_q;
    err_d   = err_q;
    pulse_d = 1'b0;
    sum_w   = int'(words_q) + BEAT;
    unique case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          if (len_words_i > LW'(MAX_WORDS)) begin
            err_d   = 1'b1;
            pulse_d = 1'b1;
          end else begin
            addr_d  = addr_i;
            len_d   = len_words_i;
            err_d   = 1'b0;
            words_d = '0;
            data_d  = '0;
            state_d = (len_words_i == '0) ? RD_DONE : RD_ASK;
          end
        end
      end
      RD_ASK: begin
        if (bus_error_i || timeout) begin
          err_d   = 1'b1;
          pulse_d = 1'b1;
          state_d = RD_IDLE;
        end else if (grant_i) begin
          state_d = RD_GRANTED;
        end
      end
      RD_GRANTED: begin
        if (bus_error_i || timeout) begin
          err_d   = 1'b1;
          pulse_d = 1'b1;
          state_d = RD_IDLE;
        end else if (beat) begin
          // Beat words past len are dropped; count saturates at len.
          for (int i = 0; i < MAX_WORDS; i++) begin
            for (int k = 0; k < BEAT; k++) begin
              if (int'(words_q) + k == i && i < int'(len_q))
                data_d[i*32 +: 32] = read_data_i[k*32 +: 32];
            end
          end
          if (sum_w >= int'(len_q)) begin
            words_d = len_q;
            state_d = RD_DONE;
          end else begin
            words_d = LW'(sum_w);
          end
        end
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      words_q <= words_d;
      data_q  <= data_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  // pulse_q marks rejected starts and aborts, which return to idle.
  assign busy_o     = (state_q != RD_IDLE);
  assign done_o     = (state_q == RD_DONE) || pulse_q;
  assign error_o    = err_q;
  assign words_o    = words_q;
  assign data_reg_o = data_q;
  assign req_o      = (state_q == RD_ASK);
  assign addr_o     = addr_q;
  assign len_o      = len_q;

endmodule

// File: tb/tb_burst_read_engine.sv
// tb_burst_read_engine: directed checks of burst_read_engine with
// a 64-bit and a 128-bit bus instance sharing one stimulus set.
module tb_burst_read_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  addr;
  logic [3:0]   len;
  logic         grant;
  logic         rv;
  logic [127:0] rd;
  logic         berr;

  logic         a_busy, a_done, a_err, a_req;
  logic [3:0]   a_words, a_len;
  logic [255:0] a_data;
  logic [31:0]  a_addr;
  logic         b_busy, b_done, b_err, b_req;
  logic [3:0]   b_words, b_len;
  logic [255:0] b_data;
  logic [31:0]  b_addr;

  int total = 0;
  int bad = 0;
  int a_done_cnt = 0;
  int a_req_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_done) a_done_cnt++;
    if (a_req) a_req_cnt++;
  end

  burst_read_engine #(
    .BUS_W(64), .MAX_WORDS(8), .TIMEOUT_CYCLES(16)
  ) u_a (
    .clk_i(clk), .reset_i(rst), .start_i(start), .addr_i(addr),
    .len_words_i(len), .busy_o(a_busy), .done_o(a_done),
    .error_o(a_err), .words_o(a_words), .data_reg_o(a_data),
    .req_o(a_req), .addr_o(a_addr), .len_o(a_len),
    .grant_i(grant), .read_valid_i(rv), .read_data_i(rd[63:0]),
    .bus_error_i(berr)
  );

  burst_read_engine #(
    .BUS_W(128), .MAX_WORDS(8), .TIMEOUT_CYCLES(16)
  ) u_b (
    .clk_i(clk), .reset_i(rst), .start_i(start), .addr_i(addr),
    .len_words_i(len), .busy_o(b_busy), .done_o(b_done),
    .error_o(b_err), .words_o(b_words), .data_reg_o(b_data),
    .req_o(b_req), .addr_o(b_addr), .len_o(b_len),
    .grant_i(grant), .read_valid_i(rv), .read_data_i(rd),
    .bus_error_i(berr)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; addr = '0; len = '0;
    grant = 1'b0; rv = 1'b0; rd = '0; berr = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({a_busy, a_done, a_err, a_req} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b exp 0000",
               {a_busy, a_done, a_err, a_req});
    end
    total++;
    if ({a_addr, a_len, a_words} !== 40'h0) begin
      bad++;
      $display("FAIL reset_regs: got %h exp 0", {a_addr, a_len, a_words});
    end
    total++;
    if (a_data !== 256'h0) begin
      bad++;
      $display("FAIL reset_data: got %h exp 0", a_data);
    end
  endtask

  task automatic test_burst64();
    int base;
    do_reset();
    base = a_done_cnt;
    start = 1'b1; addr = 32'h0000_1000; len = 4'd8;
    cyc(1);
    start = 1'b0;
    total++;
    if ({a_busy, a_req, a_addr, a_len} !== {2'b11, 32'h1000, 4'd8}) begin
      bad++;
      $display("FAIL ask_outputs: got %b%b %h %0d exp 11 1000 8",
               a_busy, a_req, a_addr, a_len);
    end
    cyc(2);
    grant = 1'b1;
    cyc(1);
    grant = 1'b0;
    total++;
    if ({a_busy, a_req} !== 2'b10) begin
      bad++;
      $display("FAIL req_drop: got %b exp 10", {a_busy, a_req});
    end
    rv = 1'b1; rd = {64'h0, 64'hA5A5_A5A5_A5A5_A5A5};
    cyc(1);
    total++;
    if (a_words !== 4'd2) begin
      bad++;
      $display("FAIL words_beat1: got %0d exp 2", a_words);
    end
    cyc(3);
    rv = 1'b0;
    total++;
    if ({a_words, a_done} !== {4'd8, 1'b1}) begin
      bad++;
      $display("FAIL burst64_end: got %0d/%b exp 8/1", a_words, a_done);
    end
    cyc(2);
    total++;
    if (a_data !== {8{32'hA5A5_A5A5}}) begin
      bad++;
      $display("FAIL burst64_data: got %h exp all a5", a_data);
    end
    total++;
    if ({a_done_cnt - base, a_err, a_busy} !== {32'd1, 2'b00}) begin
      bad++;
      $display("FAIL burst64_done: got pulses=%0d err=%b busy=%b exp 1 0 0",
               a_done_cnt - base, a_err, a_busy);
    end
  endtask

  task automatic test_burst128();
    do_reset();
    start = 1'b1; addr = 32'h0000_2000; len = 4'd6;
    cyc(1);
    start = 1'b0; grant = 1'b1;
    cyc(1);
    grant = 1'b0; rv = 1'b1;
    rd = 128'h33333333_22222222_11111111_00000000;
    cyc(1);
    total++;
    if (b_words !== 4'd4) begin
      bad++;
      $display("FAIL b_words_beat1: got %0d exp 4", b_words);
    end
    rd = 128'h77777777_66666666_55555555_44444444;
    cyc(1);
    rv = 1'b0; rd = '0;
    total++;
    if ({b_words, b_done} !== {4'd6, 1'b1}) begin
      bad++;
      $display("FAIL b_end: got %0d/%b exp 6/1", b_words, b_done);
    end
    total++;
    if (b_data !== {64'h0, 64'h55555555_44444444,
                    128'h33333333_22222222_11111111_00000000}) begin
      bad++;
      $display("FAIL b_data: got %h", b_data);
    end
  endtask

  task automatic test_len_edges();
    int dbase, rbase;
    do_reset();
    dbase = a_done_cnt; rbase = a_req_cnt;
    start = 1'b1; addr = 32'h0000_3000; len = 4'd9;
    cyc(1);
    start = 1'b0;
    total++;
    if ({a_err, a_done, a_busy, a_req} !== 4'b1100) begin
      bad++;
      $display("FAIL len9_flags: got %b exp 1100",
               {a_err, a_done, a_busy, a_req});
    end
    cyc(2);
    total++;
    if ({a_done_cnt - dbase, a_req_cnt - rbase, a_err} !==
        {32'd1, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL len9_counts: got done=%0d req=%0d err=%b exp 1 0 1",
               a_done_cnt - dbase, a_req_cnt - rbase, a_err);
    end
    start = 1'b1; addr = 32'h0000_4000; len = 4'd2;
    cyc(1);
    start = 1'b0;
    total++;
    if ({a_err, a_busy, a_req} !== 3'b011) begin
      bad++;
      $display("FAIL len2_clear: got %b exp 011", {a_err, a_busy, a_req});
    end
    grant = 1'b1;
    cyc(1);
    grant = 1'b0; rv = 1'b1; rd = {64'h0, 64'h2222_2222_1111_1111};
    cyc(1);
    rv = 1'b0;
    total++;
    if ({a_words, a_done, a_data[63:0]} !==
        {4'd2, 1'b1, 64'h2222_2222_1111_1111}) begin
      bad++;
      $display("FAIL len2_end: got %0d %b %h", a_words, a_done,
               a_data[63:0]);
    end
    cyc(2);
    dbase = a_done_cnt; rbase = a_req_cnt;
    start = 1'b1; len = 4'd0;
    cyc(1);
    start = 1'b0;
    total++;
    if ({a_done, a_busy, a_err, a_req, a_words} !== {4'b1100, 4'd0}) begin
      bad++;
      $display("FAIL len0: got %b %0d exp 1100 0",
               {a_done, a_busy, a_err, a_req}, a_words);
    end
    cyc(2);
    total++;
    if ({a_busy, a_done_cnt - dbase, a_req_cnt - rbase} !==
        {1'b0, 32'd1, 32'd0}) begin
      bad++;
      $display("FAIL len0_after: got busy=%b done=%0d req=%0d exp 0 1 0",
               a_busy, a_done_cnt - dbase, a_req_cnt - rbase);
    end
  endtask

  task automatic test_bus_error();
    do_reset();
    start = 1'b1; addr = 32'h0000_5000; len = 4'd8;
    cyc(1);
    start = 1'b0; grant = 1'b1;
    cyc(1);
    grant = 1'b0; rv = 1'b1; rd = {64'h0, 64'hBBBB_BBBB_AAAA_AAAA};
    cyc(1);
    rv = 1'b0; berr = 1'b1;
    cyc(1);
    berr = 1'b0;
    total++;
    if ({a_busy, a_err, a_done, a_words} !== {3'b011, 4'd2}) begin
      bad++;
      $display("FAIL berr_flags: got %b %0d exp 011 2",
               {a_busy, a_err, a_done}, a_words);
    end
    total++;
    if (a_data !== {192'h0, 64'hBBBB_BBBB_AAAA_AAAA}) begin
      bad++;
      $display("FAIL berr_data: got %h", a_data);
    end
    berr = 1'b1;
    cyc(1);
    berr = 1'b0;
    cyc(1);
    total++;
    if ({a_busy, a_err, a_done, a_words} !== {3'b010, 4'd2}) begin
      bad++;
      $display("FAIL berr_sticky: got %b %0d exp 010 2",
               {a_busy, a_err, a_done}, a_words);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; addr = 32'h0000_6000; len = 4'd4;
    cyc(1);
    start = 1'b0; grant = 1'b1;
    cyc(1);
    grant = 1'b0; rv = 1'b1; rd = {64'h0, 64'hDDDD_DDDD_CCCC_CCCC};
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; rv = 1'b0;
    total++;
    if ({a_busy, a_done, a_err, a_req, a_addr, a_len, a_words} !== 44'h0 ||
        a_data !== 256'h0) begin
      bad++;
      $display("FAIL reset_mid: got %b %h %0d %0d exp all 0",
               {a_busy, a_done, a_err, a_req}, a_addr, a_len, a_words);
    end
    start = 1'b1; addr = 32'h0000_7000; len = 4'd2;
    cyc(1);
    start = 1'b0; grant = 1'b1;
    cyc(1);
    grant = 1'b0; rv = 1'b1; rd = {64'h0, 64'hFFFF_0000_1234_5678};
    cyc(1);
    rv = 1'b0;
    total++;
    if ({a_words, a_done, a_err, a_data[63:0], a_addr} !==
        {4'd2, 2'b10, 64'hFFFF_0000_1234_5678, 32'h7000}) begin
      bad++;
      $display("FAIL after_reset_burst: got %0d %b%b %h %h", a_words,
               a_done, a_err, a_data[63:0], a_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; addr = 32'h0000_8000; len = 4'd2;
    cyc(1);
    start = 1'b0;
`ifdef BURST_RD_TIMEOUT_EN
    cyc(15);
    total++;
    if ({a_req, a_err, a_done} !== 3'b100) begin
      bad++;
      $display("FAIL wd_before: got %b exp 100", {a_req, a_err, a_done});
    end
    cyc(1);
    total++;
    if ({a_busy, a_req, a_err, a_done} !== 4'b0011) begin
      bad++;
      $display("FAIL wd_fire: got %b exp 0011",
               {a_busy, a_req, a_err, a_done});
    end
`else
    cyc(1000);
    total++;
    if ({a_busy, a_req, a_err, a_done} !== 4'b1100) begin
      bad++;
      $display("FAIL no_wd: got %b exp 1100",
               {a_busy, a_req, a_err, a_done});
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; len = '0;
    grant = 1'b0; rv = 1'b0; rd = '0; berr = 1'b0;
    test_reset();
    test_burst64();
    test_burst128();
    test_len_edges();
    test_bus_error();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
